// File: rtl/nand_cpu_pkg.sv
// Shared types for the NAND CPU memory hierarchy: cache request encoding and
// the main-memory controller state/owner enums.
package nand_cpu_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } CacheRequest;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_WAIT,
        MC_RBURST,
        MC_WBURST
    } MemCtrlState;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } MemCtrlOwner;

    function automatic logic isDataRequest(input CacheRequest req);
        return (req == READ) || (req == WRITE);
    endfunction

endpackage

// File: rtl/mem_ctrl_array.sv
// Single-port synchronous backing RAM; read data appears the cycle after the
// address is presented. Contents are never reset.
module mem_ctrl_array #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory responder for the I/D cache pair: round-robin arbitration, fixed
// latency, one word per beat. Define MEM_CTRL_CWF_EN for critical-word-first reads.
module mem_ctrl
    import nand_cpu_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  CacheRequest                   i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          i_ack,
    output logic                          i_rvalid,
    output logic                          i_rlast,
    output logic [$clog2(LINE_WORDS)-1:0] i_rbeat,
    output logic [WORD_W-1:0]             i_rdata,
    input  CacheRequest                   d_req,
    input  logic [ADDR_W-1:0]             d_addr,
    output logic                          d_ack,
    output logic                          d_rvalid,
    output logic                          d_rlast,
    output logic [$clog2(LINE_WORDS)-1:0] d_rbeat,
    output logic [WORD_W-1:0]             d_rdata,
    output logic                          d_wready,
    output logic [$clog2(LINE_WORDS)-1:0] d_wbeat,
    input  logic [WORD_W-1:0]             d_wdata,
    output logic                          d_done
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LATENCY - 1);
`ifdef MEM_CTRL_CWF_EN
    localparam logic CWF_EN = 1'b1;
`else
    localparam logic CWF_EN = 1'b0;
`endif

    MemCtrlState       state_q, state_d;
    MemCtrlOwner       owner_q, owner_d;
    MemCtrlOwner       lastOwner_q, lastOwner_d;
    logic              isWrite_q, isWrite_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  start_q, start_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              iAck_q, iAck_d;
    logic              dAck_q, dAck_d;
    logic              done_q, done_d;

    logic              iPend, dPend, grantToD;
    logic [OFF_W-1:0]  curIdx, nextIdx;
    logic              rValid, lastBeat;
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [WORD_W-1:0] ramRdata;

    // On contention the side that was not served last wins; WRITE from I is never pending.
    assign iPend    = (i_req == READ);
    assign dPend    = isDataRequest(d_req);
    assign grantToD = dPend && (!iPend || (lastOwner_q == OWNER_I));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MC_IDLE;
            owner_q     <= OWNER_I;
            lastOwner_q <= OWNER_I;
            isWrite_q   <= 1'b0;
            line_q      <= '0;
            start_q     <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            iAck_q      <= 1'b0;
            dAck_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            isWrite_q   <= isWrite_d;
            line_q      <= line_d;
            start_q     <= start_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            iAck_q      <= iAck_d;
            dAck_q      <= dAck_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        isWrite_d   = isWrite_q;
        line_d      = line_q;
        start_d     = start_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        iAck_d      = 1'b0;
        dAck_d      = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            MC_IDLE: begin
                if (iPend || dPend) begin
                    state_d = MC_WAIT;
                    wait_d  = '0;
                    beat_d  = '0;
                    if (grantToD) begin
                        owner_d     = OWNER_D;
                        lastOwner_d = OWNER_D;
                        isWrite_d   = (d_req == WRITE);
                        line_d      = d_addr[ADDR_W-1:OFF_W];
                        start_d     = (CWF_EN && (d_req == READ)) ? d_addr[OFF_W-1:0] : '0;
                        dAck_d      = 1'b1;
                    end else begin
                        owner_d     = OWNER_I;
                        lastOwner_d = OWNER_I;
                        isWrite_d   = 1'b0;
                        line_d      = i_addr[ADDR_W-1:OFF_W];
                        start_d     = CWF_EN ? i_addr[OFF_W-1:0] : '0;
                        iAck_d      = 1'b1;
                    end
                end
            end
            MC_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    state_d = isWrite_q ? MC_WBURST : MC_RBURST;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            MC_RBURST, MC_WBURST: begin
                beat_d = beat_q + OFF_W'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = MC_IDLE;
                    done_d  = (state_q == MC_WBURST);
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    // The RAM reads one cycle ahead, so the read address follows the next beat.
    always_comb begin
        curIdx   = start_q + beat_q;
        nextIdx  = start_q + beat_d;
        rValid   = (state_q == MC_RBURST);
        lastBeat = (beat_q == LAST_BEAT);

        i_ack    = iAck_q;
        d_ack    = dAck_q;
        d_done   = done_q;

        i_rvalid = rValid && (owner_q == OWNER_I);
        i_rlast  = i_rvalid && lastBeat;
        i_rbeat  = i_rvalid ? curIdx : '0;
        i_rdata  = i_rvalid ? ramRdata : '0;

        d_rvalid = rValid && (owner_q == OWNER_D);
        d_rlast  = d_rvalid && lastBeat;
        d_rbeat  = d_rvalid ? curIdx : '0;
        d_rdata  = d_rvalid ? ramRdata : '0;

        d_wready = (state_q == MC_WBURST);
        d_wbeat  = d_wready ? curIdx : '0;

        ramWe    = d_wready && !rst;
        ramAddr  = (state_d == MC_RBURST) ? {line_q, nextIdx} : {line_q, curIdx};
    end

    mem_ctrl_array #(
        .WORD_W(WORD_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk_i  (clk),
        .we_i   (ramWe),
        .addr_i (ramAddr),
        .wdata_i(d_wdata),
        .rdata_o(ramRdata)
    );

endmodule
